if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//  Instruction-fetch front end of the pipelined CPU: owns the PC, issues requests to a
//  fixed-latency instruction memory, buffers returned words in a DEPTH-entry queue and
//  presents them to decode with a valid/ready handshake. Taken branches and jumps from
//  the execute stage redirect the PC and squash all younger fetched and in-flight words.
// PARAMETERS
//  ADDR_W    32  PC / instruction-address width
//  DATA_W    32  instruction width
//  DEPTH     4   fetch-queue entries (power of two, >=2)
//  IMEM_LAT  1   fixed imem read latency in cycles (>=1)
// PORTS
//  CLK           in   1       single clock, all state on rising edge
//  reset         in   1       synchronous, active-high
//  resetPC       in   ADDR_W  PC loaded while reset is high
//  imem_req      out  1       read request this cycle
//  imem_addr     out  ADDR_W  word-aligned request address (bits[1:0]=0)
//  imem_rdata    in   DATA_W  data for the request issued IMEM_LAT cycles earlier
//  redirect      in   1       taken branch/jump from execute
//  redirect_pc   in   ADDR_W  new fetch target (bits[1:0] ignored, forced to 0)
//  id_valid      out  1       queue head valid to decode
//  id_ready      in   1       decode accepts head this cycle
//  id_instr      out  DATA_W  head instruction
//  id_pc         out  ADDR_W  head instruction address
//  id_pc_plus4   out  ADDR_W  id_pc + 4, modulo 2^ADDR_W
// BEHAVIOUR
//  - Reset (reset=1 at an edge): pc<=resetPC&~3, queue empty, in-flight pipe cleared;
//    imem_req=0, id_valid=0, id_instr/id_pc/id_pc_plus4=0 while reset is high.
//  - Issue: imem_req=1 iff !reset && !redirect && (count+inflight) < DEPTH (credit rule,
//    queue can never overflow); on issue pc<=pc+4 (wraps at 2^ADDR_W).
//  - Return: IMEM_LAT-deep shift register of {valid,pc} tags; word from request in cycle t
//    is written into queue at end of cycle t+IMEM_LAT; id_valid=1 in cycle t+IMEM_LAT+1.
//    First request after reset falls: addr=resetPC, in the first cycle reset is low.
//  - Handshake: pop when id_valid && id_ready; push and pop in same cycle leave count
//    unchanged; outputs hold stable while id_valid && !id_ready. id_valid = (count!=0).
//  - Redirect (level, one cycle): at that edge queue emptied, all in-flight tags
//    invalidated (their later imem_rdata discarded), pc<=redirect_pc&~3; no request that
//    cycle; first request at redirect_pc in the next cycle. A simultaneous id_ready pop
//    is subsumed by the flush. Back-to-back redirects: the last one wins.
//  - reset has priority over redirect; reset mid-operation discards everything in flight.
//  - Pointers: log2(DEPTH)-bit wrapping rd/wr pointers plus count of log2(DEPTH)+1 bits.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs perf_bubble_cnt[31:0] (cycles with reset=0 and
//  id_valid=0) and perf_flush_cnt[31:0] (cycles with redirect=1, reset=0); both
//  saturate at 32'hFFFF_FFFF, cleared by reset. Undefined: ports and logic absent,
//  all other behaviour identical.
// STRUCTURE
//  - Shared package/header if_pkg: INSTR_NOP encoding, PC_STEP=4, flush/issue enums.
//  - Sub-module if_queue: DEPTH x (DATA_W+ADDR_W) circular buffer with push, pop, flush,
//    count; fetch control (pc, credit, tag pipe) stays in if_fetch_queue.
// TESTING
//  1 Reset: resetPC=0x100, release reset -> imem_addr 0x100,0x104,0x108,0x10C on
//    consecutive cycles; id_valid rises IMEM_LAT+1 cycles after first req, id_pc=0x100.
//  2 Backpressure: id_ready=0 for 10 cycles -> exactly DEPTH requests issued, then
//    imem_req=0; head held at 0x100; id_ready=1 -> 0x100..0x10C in order, no loss/dup.
//  3 Redirect with IMEM_LAT=2, 2 in flight: redirect_pc=0x2003 -> id_valid=0 next cycle,
//    stale words dropped, next req addr=0x2000, first id_pc after flush=0x2000.
//  4 Wrap: resetPC=0xFFFF_FFFC -> second request addr=0x0000_0000, id_pc_plus4=0x0.
//  5 Reset mid-stream with full queue and redirect same cycle -> reset wins, queue empty,
//    restart at resetPC; under IF_PERF_CNT_EN both counters read 0 afterwards.

Source files
------------

// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------------------------
// if_pkg: shared definitions for the instruction-fetch front end.
//   INSTR_NOP  - canonical NOP encoding (addi x0,x0,0), shown to decode during fetch bubbles
//   PC_STEP    - sequential fetch increment in bytes
//   flush_e    - why fetch state is being discarded this cycle (reset beats redirect)
//   issue_e    - why imem is or is not being requested this cycle
//   sat_inc32  - saturating 32-bit increment used by the optional performance counters
// ---------------------------------------------------------------------------------------------
package if_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

  typedef enum logic [1:0] {
    FlushNone,
    FlushRedirect,
    FlushReset
  } flush_e;

  typedef enum logic [1:0] {
    IssueBlocked,   // reset or redirect this cycle
    IssueNoCredit,  // queue + in-flight words already fill every entry
    IssueReq
  } issue_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/if_queue.sv
// ---------------------------------------------------------------------------------------------
// if_queue: DEPTH-entry circular buffer holding fetched {instr, pc} words.
//   clk_i    - clock, all state on the rising edge
//   flush_i  - synchronous clear of pointers and count (reset or redirect)
//   push_i   - write wdata_i at the tail (caller guarantees the queue is not full)
//   wdata_i  - entry to write
//   pop_i    - drop the head entry (caller guarantees the queue is not empty)
//   rdata_o  - head entry, meaningful while count_o != 0
//   count_o  - number of valid entries, 0..DEPTH
// Push and pop in the same cycle leave the count unchanged. Flush dominates push/pop.
// ---------------------------------------------------------------------------------------------
module if_queue
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    rd_ptr_q <= rd_ptr_d;
    wr_ptr_q <= wr_ptr_d;
    cnt_q    <= cnt_d;
  end

  // Storage needs no reset: entries are only observed when count says they are valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------------------------
// if_fetch_queue: instruction-fetch front end. Owns the PC, issues word requests to a
// fixed-latency instruction memory, buffers returned words in if_queue and hands them to
// decode with a valid/ready handshake. A redirect from execute reloads the PC and squashes
// every queued and in-flight word.
//
// Ports
//   CLK, reset          - clock; synchronous active-high reset (priority over redirect)
//   resetPC             - PC loaded while reset is high (low two bits cleared)
//   imem_req/imem_addr  - read request and word-aligned address
//   imem_rdata          - data for the request issued IMEM_LAT cycles earlier
//   redirect/redirect_pc- taken branch/jump target (low two bits cleared)
//   id_valid/id_ready   - handshake to decode
//   id_instr/id_pc/id_pc_plus4 - head instruction, its address, address + 4
//
// Optional build feature, macro IF_PERF_CNT_EN: adds saturating counters
//   perf_bubble_cnt (cycles out of reset with no valid head) and
//   perf_flush_cnt  (cycles with a redirect out of reset), both cleared by reset.
// ---------------------------------------------------------------------------------------------
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned IMEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] resetPC,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_bubble_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  flush_e flush_cause;
  issue_e issue_st;

  logic [ADDR_W-1:0] pc_q, pc_d;

  // Tag pipe mirrors the imem latency: stage IMEM_LAT-1 lines up with imem_rdata.
  logic [IMEM_LAT-1:0] tag_v_q;
  logic [ADDR_W-1:0]   tag_pc_q [IMEM_LAT];

  logic [31:0]       inflight;
  logic [31:0]       credit_used;
  logic [CNT_W-1:0]  q_count;
  logic              q_flush;
  logic              q_push;
  logic              q_pop;
  logic [DATA_W+ADDR_W-1:0] q_rdata;
  logic [DATA_W-1:0] head_instr;
  logic [ADDR_W-1:0] head_pc;

  // ---------------------------------------------------------------------------
  // Flush cause and issue decision
  // ---------------------------------------------------------------------------
  always_comb begin
    flush_cause = FlushNone;
    if (reset) begin
      flush_cause = FlushReset;
    end else if (redirect) begin
      flush_cause = FlushRedirect;
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < IMEM_LAT; i++) begin
      inflight = inflight + 32'(tag_v_q[i]);
    end
  end

  // Credit counts queued words plus every word still in the memory pipe, so a word can
  // always be accepted on return even if decode never pops.
  assign credit_used = 32'(q_count) + inflight;

  always_comb begin
    issue_st = IssueReq;
    if (flush_cause != FlushNone) begin
      issue_st = IssueBlocked;
    end else if (credit_used >= DEPTH) begin
      issue_st = IssueNoCredit;
    end
  end

  assign imem_req  = (issue_st == IssueReq);
  assign imem_addr = pc_q;

  // ---------------------------------------------------------------------------
  // PC and tag pipe
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d = pc_q;
    case (flush_cause)
      FlushReset:    pc_d = resetPC & ALIGN_MASK;
      FlushRedirect: pc_d = redirect_pc & ALIGN_MASK;
      default: begin
        if (imem_req) pc_d = pc_q + ADDR_W'(PC_STEP);
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    pc_q <= pc_d;
    if (flush_cause != FlushNone) begin
      tag_v_q <= '0;
    end else begin
      tag_v_q[0] <= imem_req;
      for (int i = 1; i < IMEM_LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    tag_pc_q[0] <= pc_q;
    for (int i = 1; i < IMEM_LAT; i++) begin
      tag_pc_q[i] <= tag_pc_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch queue
  // ---------------------------------------------------------------------------
  assign q_flush = (flush_cause != FlushNone);
  assign q_push  = tag_v_q[IMEM_LAT-1] && !q_flush;
  // A pop coinciding with a redirect is subsumed by the flush.
  assign q_pop   = id_valid && id_ready && !q_flush;

  if_queue #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + ADDR_W),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk_i   (CLK),
    .flush_i (q_flush),
    .push_i  (q_push),
    .wdata_i ({imem_rdata, tag_pc_q[IMEM_LAT-1]}),
    .pop_i   (q_pop),
    .rdata_o (q_rdata),
    .count_o (q_count)
  );

  assign head_instr = q_rdata[DATA_W+ADDR_W-1:ADDR_W];
  assign head_pc    = q_rdata[ADDR_W-1:0];

  // ---------------------------------------------------------------------------
  // Decode interface: all zero in reset, NOP bubble while the queue is empty
  // ---------------------------------------------------------------------------
  always_comb begin
    id_valid    = 1'b0;
    id_instr    = '0;
    id_pc       = '0;
    id_pc_plus4 = '0;
    if (!reset) begin
      id_valid    = (q_count != '0);
      id_instr    = id_valid ? head_instr : DATA_W'(INSTR_NOP);
      id_pc       = id_valid ? head_pc : '0;
      id_pc_plus4 = id_pc + ADDR_W'(PC_STEP);
    end
  end

`ifdef IF_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] bubble_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (!id_valid) bubble_cnt_q <= sat_inc32(bubble_cnt_q);
      if (redirect)  flush_cnt_q  <= sat_inc32(flush_cnt_q);
    end
  end

  assign perf_bubble_cnt = bubble_cnt_q;
  assign perf_flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;

  logic        CLK;
  logic        reset;
  logic [31:0] resetPC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  if_fetch_queue #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .IMEM_LAT (LAT)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .resetPC     (resetPC),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_bubble_cnt (perf_bubble_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Fixed-latency instruction memory model.
  logic [31:0] ap [0:LAT-1];
  always @(posedge CLK) begin
    ap[0] <= imem_addr;
    for (int i = 1; i < LAT; i++) ap[i] <= ap[i-1];
  end
  assign imem_rdata = mem_word(ap[LAT-1]);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard of expected decode-side PCs, refilled on every fetch restart.
  logic [31:0] sb [$];
  logic [31:0] exp_req;
  int          n_acc;
  logic        first_pending;
  logic [31:0] first_acc_pc;
  logic [31:0] first_acc_p4;

  task automatic sb_restart(input logic [31:0] start);
    logic [31:0] a;
    sb.delete();
    a = start & ~32'd3;
    exp_req = a;
    for (int i = 0; i < 64; i++) begin
      sb.push_back(a);
      a = a + 32'd4;
    end
    first_pending = 1'b1;
    first_acc_pc  = 32'hDEAD_BEEF;
    first_acc_p4  = 32'hDEAD_BEEF;
  endtask

  task automatic monitor();
    logic [31:0] e;
    if (reset || redirect) return;
    if (imem_req) begin
      check("req_addr", imem_addr, exp_req);
      exp_req = exp_req + 32'd4;
    end
    if (id_valid && id_ready) begin
      n_acc = n_acc + 1;
      if (sb.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        check("id_pc", id_pc, e);
        check("id_instr", id_instr, mem_word(e));
        check("id_pc_plus4", id_pc_plus4, e + 32'd4);
      end
      if (first_pending) begin
        first_acc_pc  = id_pc;
        first_acc_p4  = id_pc_plus4;
        first_pending = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
  endtask

  int nreq;

  initial begin
    reset       = 1'b1;
    resetPC     = 32'h100;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b0;
    n_acc       = 0;
    sb_restart(32'h100);
    tick();
    tick();

    // 1: reset state
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_pc", id_pc, 32'd0);
    check("rst_instr", id_instr, 32'd0);
    check("rst_p4", id_pc_plus4, 32'd0);

    // 1+2: release, hold decode off for 10 cycles
    reset = 1'b0;
    sb_restart(32'h100);
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("bp_req", 32'(imem_req), (k < DEPTH) ? 32'd1 : 32'd0);
      check("bp_valid", 32'(id_valid), (k >= LAT + 1) ? 32'd1 : 32'd0);
      if (imem_req) nreq = nreq + 1;
      if (k == 9) check("bp_head", id_pc, 32'h100);
      tick();
    end
    check("bp_nreq", nreq, DEPTH);

    id_ready = 1'b1;
    n_acc = 0;
    for (int k = 0; k < 12; k++) tick();
    check("drain_cnt", 32'(n_acc >= DEPTH), 32'd1);

    // 3: redirect with words in flight
    check("pre_redir_inflight", 32'(dut.inflight != 0), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h2003;
    #1;
    check("redir_req", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    sb_restart(32'h2000);
    #1;
    check("post_redir_valid", 32'(id_valid), 32'd0);
    check("post_redir_req", 32'(imem_req), 32'd1);
    for (int k = 0; k < 10; k++) tick();
    check("redir_first_pc", first_acc_pc, 32'h2000);

    // 4: PC wrap
    reset   = 1'b1;
    resetPC = 32'hFFFF_FFFC;
    tick();
    reset = 1'b0;
    sb_restart(32'hFFFF_FFFC);
    for (int k = 0; k < 8; k++) tick();
    check("wrap_first_pc", first_acc_pc, 32'hFFFF_FFFC);
    check("wrap_first_p4", first_acc_p4, 32'h0);

    // 5: full queue, reset and redirect together
    id_ready = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check("full_valid", 32'(id_valid), 32'd1);
    reset       = 1'b1;
    redirect    = 1'b1;
    resetPC     = 32'h300;
    redirect_pc = 32'h4000;
    tick();
    redirect = 1'b0;
    #1;
    check("rr_valid", 32'(id_valid), 32'd0);
    check("rr_req", 32'(imem_req), 32'd0);
`ifdef IF_PERF_CNT_EN
    check("perf_bubble", perf_bubble_cnt, 32'd0);
    check("perf_flush", perf_flush_cnt, 32'd0);
`endif
    tick();
    reset    = 1'b0;
    id_ready = 1'b1;
    sb_restart(32'h300);
    #1;
    check("rr_first_req", 32'(imem_req), 32'd1);
    check("rr_first_addr", imem_addr, 32'h300);
    for (int k = 0; k < 10; k++) tick();
    check("rr_first_pc", first_acc_pc, 32'h300);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
